interboard_receiver: RTL

- Receives game messages sent by the opposing board over the inter-board GPIO link. The link is a 6-bit parallel bus with a 4-phase req/ack handshake.
- Reassembles multi-beat messages into one 24-bit word and presents it to the game controller as a single-cycle valid pulse.
- Decodes the remote-reset opcode into a pulse that the top level ORs into rstGame.
- Peer of the transmitter on the other board. Sits between the board pins and game control.

---
 rtl/interboard_receiver_pkg.sv | 30 +++
 rtl/interboard_receiver_if.sv | 12 +
 rtl/interboard_receiver_sync_2ff.sv | 33 +++
 rtl/interboard_receiver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/interboard_receiver_pkg.sv
// Shared definitions for the inter-board GPIO link (receiver and transmitter).
package interboard_receiver_pkg;

  localparam int unsigned BEAT_W        = 6;
  localparam int unsigned MSG_BEATS_DEF = 4;
  localparam int unsigned MSG_W         = 24;

  // Message field positions
  localparam int unsigned SENDER_BIT = 23;
  localparam int unsigned OPC_HI     = 22;
  localparam int unsigned OPC_LO     = 19;
  localparam int unsigned PAY_HI     = 18;
  localparam int unsigned PAY_LO     = 0;
  localparam int unsigned OPC_W      = OPC_HI - OPC_LO + 1;
  localparam int unsigned PAY_W      = PAY_HI - PAY_LO + 1;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_CARD_MOVE = 4'h1;
  localparam logic [OPC_W-1:0] OP_MOUSE_POS = 4'h2;
  localparam logic [OPC_W-1:0] OP_TURN_END  = 4'h3;
  localparam logic [OPC_W-1:0] OP_RST       = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ACK,
    ST_DONE
  } rx_state_e;

endpackage

// File: rtl/interboard_receiver_if.sv
// Inter-board link pins: 6-bit beat bus with 4-phase req/ack handshake.
interface interboard_receiver_if;
  import interboard_receiver_pkg::*;

  logic              inter_req;
  logic [BEAT_W-1:0] inter_data;
  logic              inter_ack;

  modport master (output inter_req, output inter_data, input inter_ack);
  modport slave  (input inter_req, input inter_data, output inter_ack);

endinterface

// File: rtl/interboard_receiver_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next values of the two synchroniser stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/interboard_receiver.sv
// Receives multi-beat game messages from the opposing board and pulses them out.
module interboard_receiver
  import interboard_receiver_pkg::*;
#(
  parameter logic              PLAYER      = 1'b0,
  parameter int unsigned       MSG_BEATS   = MSG_BEATS_DEF,
  parameter int unsigned       TIMEOUT_CYC = 1_000_000,
  parameter logic [OPC_W-1:0]  RST_OP      = OP_RST
) (
  input  logic                 clk,
  input  logic                 rst,
  interboard_receiver_if.slave link,
  output logic                 msg_valid,
  output logic [OPC_W-1:0]     msg_opcode,
  output logic [PAY_W-1:0]     msg_payload,
  output logic                 remote_rst,
  output logic                 link_err
);

  localparam int unsigned      CNT_W      = $clog2(MSG_BEATS + 1);
  localparam int unsigned      TO_W       = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] BEATS_LAST = CNT_W'(MSG_BEATS);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  logic              req_s;
  logic [BEAT_W-1:0] data_s;

  sync_2ff #(.WIDTH(1)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (link.inter_req),
    .q   (req_s)
  );

  sync_2ff #(.WIDTH(BEAT_W)) u_sync_data (
    .clk (clk),
    .rst (rst),
    .d   (link.inter_data),
    .q   (data_s)
  );

  rx_state_e         state_d, state_q;
  logic [CNT_W-1:0]  beat_cnt_d, beat_cnt_q;
  logic [MSG_W-1:0]  shift_d, shift_q;
  logic [TO_W-1:0]   to_d, to_q;
  logic              drain_d, drain_q;
  logic              ack_d, ack_q;
  logic              valid_d, valid_q;
  logic              rr_d, rr_q;
  logic              err_d, err_q;
  logic [OPC_W-1:0]  opcode_d, opcode_q;
  logic [PAY_W-1:0]  payload_d, payload_q;
  logic              to_run;
  logic              to_expire;

  // Handshake FSM, message assembly and mid-message timeout
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    drain_d    = drain_q;
    valid_d    = 1'b0;
    rr_d       = 1'b0;
    err_d      = 1'b0;
    opcode_d   = opcode_q;
    payload_d  = payload_q;

    case (state_q)
      ST_IDLE: begin
        // After an abort with req still high, wait for its release so the
        // stalled beat is not captured a second time.
        if (drain_q) begin
          if (!req_s) drain_d = 1'b0;
        end else if (req_s) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        shift_d    = {shift_q[MSG_W-BEAT_W-1:0], data_s};
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        state_d    = ST_ACK;
      end
      ST_ACK: begin
        if (!req_s) state_d = (beat_cnt_q == BEATS_LAST) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        beat_cnt_d = '0;
        if (shift_q[SENDER_BIT] != PLAYER) begin
          valid_d   = 1'b1;
          opcode_d  = shift_q[OPC_HI:OPC_LO];
          payload_d = shift_q[PAY_HI:PAY_LO];
          rr_d      = (shift_q[OPC_HI:OPC_LO] == RST_OP);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    to_run    = ((state_q == ST_IDLE) && (beat_cnt_q != '0)) || (state_q == ST_ACK);
    // A req fall in ACK takes priority over an expiring timeout.
    to_expire = (to_q == TO_LAST) &&
                (((state_q == ST_IDLE) && (beat_cnt_q != '0)) || ((state_q == ST_ACK) && req_s));

    if (to_expire) begin
      err_d      = 1'b1;
      beat_cnt_d = '0;
      shift_d    = '0;
      state_d    = ST_IDLE;
      drain_d    = req_s;
      to_d       = '0;
    end else if ((state_d != state_q) || !to_run) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    ack_d = (state_d == ST_ACK);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      shift_q    <= '0;
      to_q       <= '0;
      drain_q    <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      rr_q       <= 1'b0;
      err_q      <= 1'b0;
      opcode_q   <= '0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      to_q       <= to_d;
      drain_q    <= drain_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
      opcode_q   <= opcode_d;
      payload_q  <= payload_d;
    end
  end

  assign link.inter_ack = ack_q;
  assign msg_valid      = valid_q;
  assign msg_opcode     = opcode_q;
  assign msg_payload    = payload_q;
  assign remote_rst     = rr_q;
  assign link_err       = err_q;

endmodule
